// File: rtl/mdu_if.sv
// mdu_if: operand/request and result bundle between the EX-stage controller
// and the multiply/divide unit.
//   start  - single-cycle request qualifier for op
//   op     - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   data1  - rs operand (multiplicand / dividend / mthi-mtlo source)
//   data2  - rt operand (multiplier / divisor)
//   busy   - multi-cycle operation in flight
//   hi, lo - architectural HI/LO registers
// The master modport is the controller side; the slave modport is the MDU.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, data1, data2,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, data1, data2,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// mdu: MIPS multiply/divide unit with HI/LO registers.
// The 64-bit result is computed in one step on the accepting edge and held in
// a pending register; HI/LO are only written when the busy period expires.
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - mdu_if.slave: start/op/data1/data2 in, busy/hi/lo out
// Parameters: MULT_CYCLES / DIV_CYCLES give the busy length (>= 1).
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  mdu_if.slave   bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] res_q, res_d;   // pending {hi, lo}
  logic        wr_q, wr_d;     // pending result is committed at completion

  // Signed divide through magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 instead of relying on simulator overflow behaviour.
  // Returns {remainder, quotient}. A zero divisor yields a don't-care result
  // that is never committed.
  function automatic logic [63:0] div_signed(input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] ua, ub, q_mag, r_mag, q, r;
    ua = a[31] ? -a : a;
    ub = b[31] ? -b : b;
    if (ub == 32'd0) ub = 32'd1;
    q_mag = ua / ub;
    r_mag = ua % ub;
    q = (a[31] ^ b[31]) ? -q_mag : q_mag;
    r = a[31] ? -r_mag : r_mag;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] ub;
    ub = (b == 32'd0) ? 32'd1 : b;
    return {a % ub, a / ub};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT: begin
              state_d = S_MUL;
              cnt_d   = 32'(MULT_CYCLES - 1);
              res_d   = $signed(bus.data1) * $signed(bus.data2);
              wr_d    = 1'b1;
            end
            OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = 32'(MULT_CYCLES - 1);
              res_d   = {32'd0, bus.data1} * {32'd0, bus.data2};
              wr_d    = 1'b1;
            end
            OP_DIV: begin
              state_d = S_DIV;
              cnt_d   = 32'(DIV_CYCLES - 1);
              res_d   = div_signed(bus.data1, bus.data2);
              wr_d    = (bus.data2 != 32'd0);
            end
            OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = 32'(DIV_CYCLES - 1);
              res_d   = div_unsigned(bus.data1, bus.data2);
              wr_d    = (bus.data2 != 32'd0);
            end
            OP_MTHI: hi_d = bus.data1;
            OP_MTLO: lo_d = bus.data1;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        // Requests while busy are ignored entirely.
        if (cnt_q == 32'd0) begin
          state_d = S_IDLE;
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wr_q    <= wr_d;
    end
  end

  // Pending result is pure data; leaving IDLE is what makes it meaningful.
  always_ff @(posedge clk) begin
    res_q <= res_d;
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
